// File: rtl/pipe_pkg.sv
// Shared widths, field offsets and control-field structs for the pipeline stage registers.
package pipe_pkg;

  localparam int unsigned REG_W  = 32;
  localparam int unsigned ADDR_W = 5;

  // ID/EX control packing (MSB to LSB): regwrite, memtoreg, memwrite, alucontrol[2:0], alusrc, regdst
  localparam int unsigned IDEX_CTRL_W          = 8;
  localparam int unsigned IDEX_REGWRITE_BIT    = 7;
  localparam int unsigned IDEX_MEMTOREG_BIT    = 6;
  localparam int unsigned IDEX_MEMWRITE_BIT    = 5;
  localparam int unsigned IDEX_ALUCONTROL_LSB  = 2;
  localparam int unsigned IDEX_ALUCONTROL_W    = 3;
  localparam int unsigned IDEX_ALUSRC_BIT      = 1;
  localparam int unsigned IDEX_REGDST_BIT      = 0;

  // ID/EX data packing from LSB: pcplus4, SignImm, rd, rt, rs, rd2, rd1; bits above rd1 are reserved
  localparam int unsigned IDEX_DATA_W          = 175;
  localparam int unsigned IDEX_PCPLUS4_LSB     = 0;
  localparam int unsigned IDEX_SIGNIMM_LSB     = IDEX_PCPLUS4_LSB + REG_W;
  localparam int unsigned IDEX_RD_LSB          = IDEX_SIGNIMM_LSB + REG_W;
  localparam int unsigned IDEX_RT_LSB          = IDEX_RD_LSB + ADDR_W;
  localparam int unsigned IDEX_RS_LSB          = IDEX_RT_LSB + ADDR_W;
  localparam int unsigned IDEX_RD2_LSB         = IDEX_RS_LSB + ADDR_W;
  localparam int unsigned IDEX_RD1_LSB         = IDEX_RD2_LSB + REG_W;

  localparam int unsigned EXMEM_CTRL_W         = 3;
  localparam int unsigned MEMWB_CTRL_W         = 2;

  typedef struct packed {
    logic       regwrite;
    logic       memtoreg;
    logic       memwrite;
    logic [2:0] alucontrol;
    logic       alusrc;
    logic       regdst;
  } idex_ctrl_t;

  typedef struct packed {
    logic regwrite;
    logic memtoreg;
    logic memwrite;
  } exmem_ctrl_t;

  typedef struct packed {
    logic regwrite;
    logic memtoreg;
  } memwb_ctrl_t;

  localparam int unsigned DEF_CTRL_W     = IDEX_CTRL_W;
  localparam int unsigned DEF_DATA_W     = IDEX_DATA_W;
  localparam int unsigned DEF_SKID       = 1;
  localparam int unsigned DEF_CLEAR_DATA = 0;

endpackage

// File: rtl/pipe_stage_reg_slot.sv
// One pipeline entry: valid + ctrl + data. Kill clears valid and ctrl, and data when zero_data is set.
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int unsigned CTRL_W = DEF_CTRL_W,
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              kill,
  input  logic              zero_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              valid,
  output logic [CTRL_W-1:0] ctrl,
  output logic [DATA_W-1:0] data
);

  // Ctrl is cleared with valid so an empty slot always reads as a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      ctrl  <= '0;
      data  <= '0;
    end else if (kill) begin
      valid <= 1'b0;
      ctrl  <= '0;
      if (zero_data) data <= '0;
    end else if (load) begin
      valid <= 1'b1;
      ctrl  <= in_ctrl;
      data  <= in_data;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, synchronous flush and optional skid entry.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned CTRL_W              = DEF_CTRL_W,
  parameter int unsigned DATA_W              = DEF_DATA_W,
  parameter int unsigned SKID                = DEF_SKID,
  parameter int unsigned CLEAR_DATA_ON_FLUSH = DEF_CLEAR_DATA
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occ
);

  logic              push, pop;
  logic              s_valid;
  logic [CTRL_W-1:0] s_ctrl;
  logic [DATA_W-1:0] s_data;
  logic              m_load, m_from_s, m_kill, s_load, s_kill;
  logic              m_valid_nxt, s_valid_nxt;
  logic              zero_data;
  logic [CTRL_W-1:0] m_ctrl_in;
  logic [DATA_W-1:0] m_data_in;
  logic              ready_q;
  logic [1:0]        occ_q;

  assign in_ready  = (SKID != 0) ? ready_q : (~out_valid | out_ready);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign zero_data = flush & (CLEAR_DATA_ON_FLUSH != 0);
  assign m_ctrl_in = m_from_s ? s_ctrl : in_ctrl;
  assign m_data_in = m_from_s ? s_data : in_data;
  assign occ       = occ_q;

  // Entry control: flush wins, then a full skid drains into main, then main loads or drains.
  always_comb begin
    m_load   = 1'b0;
    m_from_s = 1'b0;
    m_kill   = 1'b0;
    s_load   = 1'b0;
    s_kill   = 1'b0;
    if (flush) begin
      m_kill = 1'b1;
      s_kill = 1'b1;
    end else if (s_valid) begin
      if (pop) begin
        m_load   = 1'b1;
        m_from_s = 1'b1;
        s_kill   = 1'b1;
      end
    end else if (!out_valid || pop) begin
      if (push)     m_load = 1'b1;
      else if (pop) m_kill = 1'b1;
    end else if (push) begin
      s_load = (SKID != 0);
    end
    m_valid_nxt = m_load | (out_valid & ~m_kill);
    s_valid_nxt = s_load | (s_valid & ~s_kill);
  end

  pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (m_load),
    .kill      (m_kill),
    .zero_data (zero_data),
    .in_ctrl   (m_ctrl_in),
    .in_data   (m_data_in),
    .valid     (out_valid),
    .ctrl      (out_ctrl),
    .data      (out_data)
  );

  generate
    if (SKID != 0) begin : g_skid
      pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (s_load),
        .kill      (s_kill),
        .zero_data (zero_data),
        .in_ctrl   (in_ctrl),
        .in_data   (in_data),
        .valid     (s_valid),
        .ctrl      (s_ctrl),
        .data      (s_data)
      );
    end else begin : g_no_skid
      assign s_valid = 1'b0;
      assign s_ctrl  = '0;
      assign s_data  = '0;
    end
  endgenerate

  // Registered ready (skid free next cycle) and occupancy count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q <= 1'b1;
      occ_q   <= 2'd0;
    end else begin
      ready_q <= ~s_valid_nxt;
      occ_q   <= 2'(m_valid_nxt) + 2'(s_valid_nxt);
    end
  end

endmodule
